// File: rtl/instr_decode_queue_pkg.sv
// rtl/instr_decode_queue_pkg.sv - shared RV32I decode types, opcodes and exception codes
package riscV_unrn_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  localparam logic [31:0] EXC_ILLEGAL_INSTR = 32'd2;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    instr_fmt_t  fmt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        illegal;
    logic [31:0] exc_cause;
  } decoded_entry_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// rtl/instr_decode_queue_if.sv - fetch-side and execute-side handshake bundle of the decode queue
interface instr_decode_queue_if;
  import riscV_unrn_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  instr_fmt_t  out_type;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [31:0] out_exc_cause;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2,
           out_rd, out_imm, out_type, out_pc, out_instr, out_illegal, out_exc_cause
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2,
           out_rd, out_imm, out_type, out_pc, out_instr, out_illegal, out_exc_cause
  );

endinterface

// File: rtl/instr_decode_queue_decoder.sv
// rtl/instr_decode_queue_decoder.sv - combinational RV32I decoder, raw word + pc to decoded entry
module instr_decoder
  import riscV_unrn_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  logic [31:0]    pc_i,
  output decoded_entry_t entry_o
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  instr_fmt_t  fmt;
  logic [31:0] imm;

  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  always_comb begin
    legal = 1'b0;
    fmt   = FMT_R;
    case (instr_i[6:0])
      OPC_LOAD:     begin fmt = FMT_I; legal = (f3 != 3'b011) && (f3[2:1] != 2'b11); end
      OPC_STORE:    begin fmt = FMT_S; legal = !f3[2] && (f3 != 3'b011); end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        fmt   = FMT_R;
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; legal = 1'b1; end
      OPC_JAL:      begin fmt = FMT_J; legal = 1'b1; end
      OPC_JALR:     begin fmt = FMT_I; legal = (f3 == 3'b000); end
      OPC_BRANCH:   begin fmt = FMT_B; legal = (f3[2:1] != 2'b01); end
      OPC_MISC_MEM: begin fmt = FMT_I; legal = (f3[2:1] == 2'b00); end
      OPC_SYSTEM: begin
        fmt = FMT_I;
        // f3=000 carries only the three privileged words; every other f3 is a CSR op except 100
        if (f3 == 3'b000)
          legal = (instr_i == INSTR_ECALL) || (instr_i == INSTR_EBREAK) || (instr_i == INSTR_MRET);
        else
          legal = (f3 != 3'b100);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I:   imm = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm = {instr_i[31:12], 12'd0};
      FMT_J:   imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  always_comb begin
    entry_o       = '0;
    entry_o.pc    = pc_i;
    entry_o.instr = instr_i;
    if (legal) begin
      entry_o.opcode = instr_i[6:0];
      entry_o.funct3 = f3;
      entry_o.funct7 = f7;
      entry_o.rs1    = instr_i[19:15];
      entry_o.rs2    = instr_i[24:20];
      entry_o.rd     = instr_i[11:7];
      entry_o.imm    = imm;
      entry_o.fmt    = fmt;
    end else begin
      entry_o.illegal   = 1'b1;
      entry_o.exc_cause = EXC_ILLEGAL_INSTR;
    end
  end

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - decode-at-enqueue instruction FIFO between fetch and execute
module instr_decode_queue
  import riscV_unrn_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  instr_decode_queue_if.slave        q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  decoded_entry_t mem_q [DEPTH];
  decoded_entry_t dec_entry;
  decoded_entry_t head;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic           push, pop;

  instr_decoder u_dec (
    .instr_i (q_if.in_instr),
    .pc_i    (q_if.in_pc),
    .entry_o (dec_entry)
  );

  // in_ready looks only at occupancy so a pop never opens a full queue in the same cycle
  assign q_if.in_ready  = (occ_q < DEPTH_C);
  assign q_if.out_valid = (occ_q != '0);
  assign push = q_if.in_valid && q_if.in_ready && !flush;
  assign pop  = q_if.out_valid && q_if.out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push) mem_q[wr_ptr_q] <= dec_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign occupancy          = occ_q;
  assign q_if.out_opcode    = head.opcode;
  assign q_if.out_funct3    = head.funct3;
  assign q_if.out_funct7    = head.funct7;
  assign q_if.out_rs1       = head.rs1;
  assign q_if.out_rs2       = head.rs2;
  assign q_if.out_rd        = head.rd;
  assign q_if.out_imm       = head.imm;
  assign q_if.out_type      = head.fmt;
  assign q_if.out_pc        = head.pc;
  assign q_if.out_instr     = head.instr;
  assign q_if.out_illegal   = head.illegal;
  assign q_if.out_exc_cause = head.exc_cause;

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Registered RV32I decode stage with a parametrised instruction queue. It accepts raw instruction words and their PCs from fetch over a valid/ready handshake, and fully decodes each one at enqueue. Decoding covers field extraction, sign-extended immediate, format class and illegal-instruction detection, including SYSTEM/CSR/FENCE. It buffers up to DEPTH decoded entries for the execute stage, with in-order delivery and single-cycle flush on redirect or trap.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; = (occupancy < DEPTH)
- in_instr  in  32  raw instruction word
- in_pc  in  32  PC of in_instr
- flush  in  1  discard all queued entries and any same-cycle input
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_opcode  out  7;  out_funct3  out  3;  out_funct7  out  7
- out_rs1, out_rs2, out_rd  out  5 each
- out_imm  out  32  sign-extended immediate, 0 for R-type
- out_type  out  3  instr_fmt_t format class
- out_pc  out  32;  out_instr  out  32  raw word, for mtval
- out_illegal  out  1  head entry is an illegal instruction
- out_exc_cause  out  32  2 when out_illegal, else 0
- occupancy  out  $clog2(DEPTH+1)  entries held

## Operation
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush. Push and pop may occur in the same cycle.
- Entries are decoded combinationally at push and stored decoded. The queue is FIFO-ordered, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Immediates:
  - I-type: sext(instr[31:20]).
  - S-type: sext({[31:25],[11:7]}).
  - B-type: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U-type: {[31:12],12'b0}.
  - J-type: sext({[31],[19:12],[20],[30:21],1'b0}).
- Format classes: R=0, I=1, S=2, B=3, U=4, J=5.
- Legal opcodes: LOAD (f3 000,001,010,100,101); STORE (f3 000–010); OP-IMM; OP (RV32I funct7/funct3 pairs only); LUI; AUIPC; JAL; JALR (f3 000); BRANCH (f3 ≠ 010,011); MISC-MEM (f3 000 fence, 001 fence.i); SYSTEM.
- OP-IMM shift rules: slli requires funct7=0; srli requires funct7=0; srai requires funct7=0100000.
- SYSTEM: the only legal words are 0x00000073 (ecall), 0x00100073 (ebreak) and 0x30200073 (mret), plus CSR f3 ∈ {001,010,011,101,110,111}. f3=100 is illegal.
- Illegal entries: instr[1:0] ≠ 11 or any other encoding not listed above. The entry sets out_illegal=1 and out_exc_cause=2, keeps pc and instr, and sets all decoded fields and imm to 0.
- The occupancy counter tracks pushes minus pops.

## Timing
- Reset: pointers and occupancy are 0, out_valid=0, in_ready=1. All out_* data fields read 0.
- Latency: a word pushed at edge N appears at the head with out_valid=1 after edge N when the queue was empty. There is no combinational in→out bypass.
- in_ready depends only on occupancy, not on out_ready. When full, a same-cycle pop does not open the input.
- Full (occupancy=DEPTH): in_ready=0; input is held by fetch.
- Empty: out_valid=0. The output fields then hold the last head value, and consumers ignore them.
- flush: at the next edge, pointers and occupancy are 0 and out_valid=0. Any same-cycle push and pop are both suppressed. Flush takes priority over every other event.
- Reset asserted mid-operation: the queue clears immediately and asynchronously. Entries are lost.
- Output data is registered storage read at the head pointer. The read mux is combinational from the pointer.

## Structure
- Shared package riscV_unrn_pkg holds:
  - instr_fmt_t, a 3-bit enum with the codes above.
  - decoded_entry_t, a packed struct of every out_* field except out_valid.
  - Opcode localparams (OPC_LOAD … OPC_SYSTEM).
  - EXC_ILLEGAL_INSTR = 2.
- Sub-module instr_decoder: purely combinational, raw word + pc → decoded_entry_t. Reused by a future trap path.
- The FIFO storage, pointers and handshake live in instr_decode_queue.

## Test plan
- Push 0xFFF00093 (addi x1,x0,-1) at pc 0x100 → one cycle later: out_valid=1, type=I, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- Push 0x0020A423 (sw x2,8(x1)), 0xFE000EE3 (beq -4) and 0x123452B7 (lui x5) back-to-back with out_ready=1 → same order out:
  - sw: imm=8, type=S.
  - beq: imm=0xFFFFFFFC, type=B.
  - lui: imm=0x12345000, rd=5, type=U.
- Push 0x00000000, 0x4020D093 with funct7 changed to 0000001 (0x0020D093→0x0220D093), and 0x00004073 → each has illegal=1, cause=2, and out_instr equal to the pushed word. 0x30200073 → illegal=0.
- DEPTH=2, out_ready=0, push 3 words → in_ready=0 after 2 accepts, occupancy=2. Raise out_ready → first two words pop in order, then the third is accepted.
- Fill with 2 entries, assert flush while also pushing → next cycle: occupancy=0, out_valid=0, pushed word discarded.
- Assert rst_n low mid-stream, between clock edges → out_valid falls immediately and occupancy=0 without a clock edge.
